// File: rtl/pipe_hazard_ctrl.sv
// Control-path sequencer for a 5-stage pipeline: carries decoder control through
// ID/EX, EX/MEM and MEM/WB, resolves load-use / branch / memory-wait hazards and forwarding.

module pipe_hazard_fwd_sel (
    input  logic [4:0] i_src,
    input  logic       i_exmem_rw,
    input  logic [4:0] i_exmem_dst,
    input  logic       i_memwb_rw,
    input  logic [4:0] i_memwb_dst,
    output logic [1:0] o_sel
);
    // Youngest producer wins; $0 is hard-wired zero and never forwarded.
    always_comb begin
        o_sel = 2'b00;
        if (i_exmem_rw && (i_exmem_dst != 5'd0) && (i_exmem_dst == i_src))
            o_sel = 2'b10;
        else if (i_memwb_rw && (i_memwb_dst != 5'd0) && (i_memwb_dst == i_src))
            o_sel = 2'b01;
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_id_wb,
    input  logic [2:0]       i_id_m,
    input  logic [3:0]       i_id_ex,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic [4:0]       i_id_rd,
    input  logic             i_mem_zero,
    input  logic             i_ext_stall,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_pcsrc,
    output logic [1:0]       o_idex_wb,
    output logic [2:0]       o_idex_m,
    output logic [3:0]       o_idex_ex,
    output logic [1:0]       o_exmem_wb,
    output logic [2:0]       o_exmem_m,
    output logic [1:0]       o_memwb_wb,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    logic [1:0]       r_idex_wb;
    logic [2:0]       r_idex_m;
    logic [3:0]       r_idex_ex;
    logic [4:0]       r_idex_rs, r_idex_rt, r_idex_rd;
    logic [1:0]       r_exmem_wb;
    logic [2:0]       r_exmem_m;
    logic [4:0]       r_exmem_dst;
    logic [1:0]       r_memwb_wb;
    logic [4:0]       r_memwb_dst;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_br_taken, w_lu, w_freeze, w_flush, w_stall;
    logic [1:0][4:0] w_src;
    logic [1:0][1:0] w_sel;

    assign w_br_taken = r_exmem_m[2] & i_mem_zero;
    assign w_lu = r_idex_m[1] & (r_idex_rt != 5'd0) &
                  ((r_idex_rt == i_id_rs) |
                   ((r_idex_rt == i_id_rt) & (i_id_ex[3] | i_id_m[0] | i_id_m[2])));

    // Priority: memory wait > taken branch > load-use; a flush kills the ID instruction.
    assign w_freeze = i_ext_stall;
    assign w_flush  = ~w_freeze & w_br_taken;
    assign w_stall  = ~w_freeze & ~w_br_taken & w_lu;

    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_pcsrc      = 1'b0;
        if (!i_rst_n) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
        end else if (w_freeze || w_stall) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (w_flush) begin
            o_pcsrc      = 1'b1;
            o_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idex_wb   <= '0;
            r_idex_m    <= '0;
            r_idex_ex   <= '0;
            r_idex_rs   <= '0;
            r_idex_rt   <= '0;
            r_idex_rd   <= '0;
            r_exmem_wb  <= '0;
            r_exmem_m   <= '0;
            r_exmem_dst <= '0;
            r_memwb_wb  <= '0;
            r_memwb_dst <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_freeze) begin
            r_idex_rs <= i_id_rs;
            r_idex_rt <= i_id_rt;
            r_idex_rd <= i_id_rd;
            if (w_flush || w_stall) begin
                r_idex_wb <= '0;
                r_idex_m  <= '0;
                r_idex_ex <= '0;
            end else begin
                r_idex_wb <= i_id_wb;
                r_idex_m  <= i_id_m;
                r_idex_ex <= i_id_ex;
            end

            r_exmem_dst <= r_idex_ex[3] ? r_idex_rd : r_idex_rt;
            if (w_flush) begin
                r_exmem_wb <= '0;
                r_exmem_m  <= '0;
            end else begin
                r_exmem_wb <= r_idex_wb;
                r_exmem_m  <= r_idex_m;
            end

            r_memwb_wb  <= r_exmem_wb;
            r_memwb_dst <= r_exmem_dst;

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // One selector per ALU operand: index 1 = rs (A), index 0 = rt (B).
    assign w_src = {r_idex_rs, r_idex_rt};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_fwd
            pipe_hazard_fwd_sel u_sel (
                .i_src       (w_src[g]),
                .i_exmem_rw  (r_exmem_wb[1]),
                .i_exmem_dst (r_exmem_dst),
                .i_memwb_rw  (r_memwb_wb[1]),
                .i_memwb_dst (r_memwb_dst),
                .o_sel       (w_sel[g])
            );
        end
    endgenerate

    assign o_fwd_a     = w_sel[1];
    assign o_fwd_b     = w_sel[0];
    assign o_idex_wb   = r_idex_wb;
    assign o_idex_m    = r_idex_m;
    assign o_idex_ex   = r_idex_ex;
    assign o_exmem_wb  = r_exmem_wb;
    assign o_exmem_m   = r_exmem_m;
    assign o_memwb_wb  = r_memwb_wb;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: an instruction-level pipeline model predicts
// every cycle's outputs; a monitor compares them at the falling edge.

module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, mem_zero, ext_stall;
    logic [1:0]       id_wb;
    logic [2:0]       id_m;
    logic [3:0]       id_ex;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic             pc_write, ifid_write, ifid_flush, pcsrc;
    logic [1:0]       idex_wb, exmem_wb, memwb_wb, fwd_a, fwd_b;
    logic [2:0]       idex_m, exmem_m;
    logic [3:0]       idex_ex;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_wb(id_wb), .i_id_m(id_m), .i_id_ex(id_ex),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd), .i_mem_zero(mem_zero),
        .i_ext_stall(ext_stall), .o_pc_write(pc_write), .o_ifid_write(ifid_write),
        .o_ifid_flush(ifid_flush), .o_pcsrc(pcsrc), .o_idex_wb(idex_wb), .o_idex_m(idex_m),
        .o_idex_ex(idex_ex), .o_exmem_wb(exmem_wb), .o_exmem_m(exmem_m),
        .o_memwb_wb(memwb_wb), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [1:0] wb; logic [2:0] m; logic [3:0] ex;
        logic [4:0] rs, rt, rd;
    } ins_t;

    typedef struct {
        bit             known;
        bit             wdc;      // ifid_write unconstrained on a flush
        logic [3:0]     ctrl;     // {pc_write, ifid_write, ifid_flush, pcsrc}
        logic [8:0]     idex;
        logic [4:0]     exmem;
        logic [1:0]     memwb;
        logic [3:0]     fwd;
        logic [2*CNT_W-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    ins_t s_ex, s_mem, s_wb;      // instruction occupying ID/EX, EX/MEM, MEM/WB
    int   n_stall = 0, n_flush = 0;
    int   checks = 0, errors = 0;

    localparam int K_NOP = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;

    function automatic ins_t mk(int kind, int rs, int rt, int rd);
        ins_t i;
        i = '0;
        i.rs = rs[4:0]; i.rt = rt[4:0]; i.rd = rd[4:0];
        case (kind)
            K_R:   begin i.wb = 2'b10; i.m = 3'b000; i.ex = 4'b1100; end
            K_LW:  begin i.wb = 2'b11; i.m = 3'b010; i.ex = 4'b0001; end
            K_SW:  begin i.wb = 2'b00; i.m = 3'b001; i.ex = 4'b0001; end
            K_BEQ: begin i.wb = 2'b00; i.m = 3'b100; i.ex = 4'b0010; end
            default: ;
        endcase
        return i;
    endfunction

    function automatic ins_t bubble(ins_t i);
        ins_t b;
        b = i;
        b.wb = '0; b.m = '0; b.ex = '0;
        return b;
    endfunction

    function automatic logic [4:0] dst(ins_t i);
        return i.ex[3] ? i.rd : i.rt;
    endfunction

    function automatic logic [1:0] fsel(logic [4:0] s);
        if (s_mem.wb[1] && dst(s_mem) != 0 && dst(s_mem) == s) return 2'b10;
        if (s_wb.wb[1] && dst(s_wb) != 0 && dst(s_wb) == s) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one cycle, predict what the DUT shows during it, then advance the model at the edge.
    task automatic step(input ins_t id, input logic zero, input logic stall,
                        input logic rst, input bit known);
        exp_t e;
        ins_t nx_ex, nx_mem, nx_wb;
        bit br, lu;
        int ns, nf;
        id_wb = id.wb; id_m = id.m; id_ex = id.ex;
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
        mem_zero = zero; ext_stall = stall; rst_n = rst;

        br = s_mem.m[2] && zero;
        lu = s_ex.m[1] && s_ex.rt != 0 &&
             (s_ex.rt == id.rs || (s_ex.rt == id.rt && (id.ex[3] || id.m[0] || id.m[2])));

        e.known = known; e.wdc = 1'b0;
        e.idex  = {s_ex.wb, s_ex.m, s_ex.ex};
        e.exmem = {s_mem.wb, s_mem.m};
        e.memwb = s_wb.wb;
        e.fwd   = {fsel(s_ex.rs), fsel(s_ex.rt)};
        e.cnt   = {n_stall[CNT_W-1:0], n_flush[CNT_W-1:0]};

        nx_ex = id; nx_mem = s_ex; nx_wb = s_mem;
        ns = n_stall; nf = n_flush;
        if (!rst) begin
            e.ctrl = 4'b0010;
            nx_ex = '0; nx_mem = '0; nx_wb = '0; ns = 0; nf = 0;
        end else if (stall) begin
            e.ctrl = 4'b0000;
            nx_ex = s_ex; nx_mem = s_mem; nx_wb = s_wb;
        end else if (br) begin
            e.ctrl = 4'b1111; e.wdc = 1'b1;
            nx_ex = bubble(id); nx_mem = bubble(s_ex);
            nf = (n_flush < CMAX) ? n_flush + 1 : CMAX;
        end else if (lu) begin
            e.ctrl = 4'b0000;
            nx_ex = bubble(id);
            ns = (n_stall < CMAX) ? n_stall + 1 : CMAX;
        end else begin
            e.ctrl = 4'b1100;
        end
        sbq.push_back(e);

        @(posedge clk);
        s_ex = nx_ex; s_mem = nx_mem; s_wb = nx_wb; n_stall = ns; n_flush = nf;
        #1;
    endtask

    task automatic run(input ins_t id, input logic zero = 1'b0, input logic stall = 1'b0);
        step(id, zero, stall, 1'b1, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every falling edge the DUT presents a full output set for the current cycle.
    initial begin
        exp_t e;
        logic [3:0] ac;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e  = sbq.pop_front();
                ac = {pc_write, ifid_write, ifid_flush, pcsrc};
                if (e.wdc) ac[2] = e.ctrl[2];
                chk("ctrl", 32'(ac), 32'(e.ctrl));
                if (e.known) begin
                    chk("idex",  32'({idex_wb, idex_m, idex_ex}), 32'(e.idex));
                    chk("exmem", 32'({exmem_wb, exmem_m}), 32'(e.exmem));
                    chk("memwb", 32'(memwb_wb), 32'(e.memwb));
                    chk("fwd",   32'({fwd_a, fwd_b}), 32'(e.fwd));
                    chk("cnt",   32'({stall_cnt, flush_cnt}), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        ins_t nop, r;
        nop = mk(K_NOP, 0, 0, 0);
        s_ex = '0; s_mem = '0; s_wb = '0;
        rst_n = 1'b0; mem_zero = 1'b0; ext_stall = 1'b0;
        {id_wb, id_m, id_ex, id_rs, id_rt, id_rd} = '0;
        @(posedge clk); #1;

        // Reset with a random bundle in ID, then an R-type through the pipe
        step(ins_t'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        step(ins_t'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        run(mk(K_R, 1, 2, 3));
        repeat (4) run(nop);

        // Load-use: exactly one bubble; rt=$0 never stalls
        run(mk(K_LW, 1, 2, 0));
        run(mk(K_R, 2, 3, 4));
        run(mk(K_R, 2, 3, 4));
        run(mk(K_LW, 1, 0, 0));
        run(mk(K_R, 0, 0, 4));
        repeat (3) run(nop);

        // Forwarding: both stages, MEM/WB only, and $0 destination
        run(mk(K_R, 1, 1, 5)); run(mk(K_R, 1, 1, 5)); run(mk(K_R, 5, 5, 6)); run(nop);
        run(mk(K_R, 1, 1, 5)); run(nop); run(mk(K_R, 5, 1, 6)); run(nop);
        run(mk(K_R, 1, 1, 0)); run(mk(K_R, 0, 0, 6)); run(nop); run(nop);

        // Taken branch colliding with a load-use, then an untaken branch
        run(mk(K_BEQ, 1, 2, 0)); run(mk(K_LW, 1, 4, 0)); run(mk(K_R, 4, 1, 7), 1'b1);
        repeat (3) run(nop);
        run(mk(K_BEQ, 1, 2, 0)); run(nop); run(nop, 1'b0); run(nop);

        // Memory wait holding a taken branch in EX/MEM, then release
        run(mk(K_BEQ, 1, 2, 0)); run(nop);
        repeat (3) run(mk(K_R, 1, 2, 3), 1'b1, 1'b1);
        run(nop, 1'b1); run(nop);

        // Drive the stall counter into saturation
        repeat (20) begin
            run(mk(K_LW, 1, 2, 0));
            run(mk(K_R, 2, 1, 3));
        end
        run(nop); run(nop);

        // Random traffic over a small register set so hazards are frequent
        repeat (2000) begin
            r = mk($urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 199) == 0)
                step(r, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            else
                step(r, 1'($urandom), ($urandom_range(0, 6) == 0), 1'b1, 1'b1);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequences the 5-stage pipeline control path. Carries the decoder's WB/M/EX control bundles through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and inserts bubbles, flushes on a taken beq, freezes on an external memory wait, and drives the forwarding selects. Sits between the instruction decoder and the datapath pipeline registers.

Parameters:
CNT_W, 16, width of the saturating stall and flush performance counters.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  synchronous active-low reset
id_wb  in  2  {RegWrite, MemtoReg} of the instruction in ID
id_m  in  3  {Branch, MemRead, MemWrite} of the instruction in ID
id_ex  in  4  {RegDst, ALUOp[1:0], ALUSrc} of the instruction in ID
id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID
mem_zero  in  1  ALU zero flag registered into EX/MEM
ext_stall  in  1  memory not ready; freezes the whole pipeline
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID to a NOP
pcsrc  out  1  select branch target for the next PC
idex_wb, idex_m, idex_ex  out  2/3/4  registered ID/EX control
exmem_wb, exmem_m  out  2/3  registered EX/MEM control
memwb_wb  out  2  registered MEM/WB control
fwd_a, fwd_b  out  2 each  ALU operand A/B select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB
stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

Behaviour:
- Reset (rst_n=0 at a clk edge): all control registers, internal idex_rs/rt/rd and exmem_dst/memwb_dst cleared to 0; counters cleared to 0. While rst_n=0: pc_write=0, ifid_write=0, pcsrc=0, ifid_flush=1. Reset mid-operation discards all in-flight control; nothing is retained.
- Register advance, normal cycle:
  - ID/EX takes the id_* bundle and fields.
  - EX/MEM takes idex_wb and idex_m, plus exmem_dst = idex_ex[3] ? idex_rd : idex_rt.
  - MEM/WB takes exmem_wb and memwb_dst = exmem_dst.
  - Latency per stage is 1 clk.
- Bubble means the wb/m/ex fields are loaded as 0; register fields may still load.
- Taken branch: br_taken = exmem_m[2] & mem_zero.
- Load-use hazard: lu = idex_m[1] & (idex_rt != 0) & ((idex_rt == id_rs) | ((idex_rt == id_rt) & (id_ex[3] | id_m[0] | id_m[2]))).
- Action priority, evaluated each cycle, highest first:
  1. FREEZE (ext_stall=1): every register holds; pc_write=0, ifid_write=0, pcsrc=0, ifid_flush=0; counters hold. A pending branch is re-evaluated on release because EX/MEM is held.
  2. FLUSH (br_taken): pcsrc=1, pc_write=1, ifid_flush=1. ID/EX and EX/MEM load bubbles; MEM/WB advances normally. flush_cnt increments. Any simultaneous lu is ignored because the ID instruction is killed.
  3. STALL (lu): pc_write=0, ifid_write=0. ID/EX loads a bubble; EX/MEM and MEM/WB advance. stall_cnt increments. Exactly one bubble per load-use pair, since the load then moves to MEM and lu deasserts.
  4. RUN: pc_write=1, ifid_write=1, pcsrc=0, ifid_flush=0; all registers advance.
- Forwarding, combinational from registered state, computed for idex_rs (fwd_a) and idex_rt (fwd_b):
  - 10 if exmem_wb[1] & exmem_dst != 0 & exmem_dst matches the source;
  - else 01 if memwb_wb[1] & memwb_dst != 0 & memwb_dst matches the source;
  - else 00.
  - EX/MEM has priority over MEM/WB. Register $0 is never forwarded.
- Counters saturate at all-ones and never wrap.
- Unknown opcodes arrive as an all-zero bundle from the decoder and travel as a NOP.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with a random id_* bundle -> all control outputs 0, counters 0, pc_write=0, ifid_flush=1; after release with an R-type bundle (wb=10, m=000, ex=1100) -> idex_wb=10 one clk later, memwb_wb=10 three clks later.
- Load-use: lw $2 (wb=11, m=010, idex_rt=2) in EX, add with id_rs=2 in ID -> pc_write=0, ifid_write=0 for exactly 1 clk, idex_* = 0 next clk, stall_cnt=1. Same case with idex_rt=0 -> no stall.
- Forwarding: add writing $5 in EX/MEM and in MEM/WB, next add with idex_rs=5 -> fwd_a=10; with only MEM/WB writing $5 -> fwd_a=01; with dst=$0 -> 00.
- Branch: beq (m=100) reaches EX/MEM with mem_zero=1 while a lu condition also holds -> pcsrc=1, ifid_flush=1, idex and exmem control 0 next clk, flush_cnt=1, stall_cnt unchanged. With mem_zero=0 -> no flush.
- Freeze: assert ext_stall for 3 clks while a taken beq sits in EX/MEM -> all registers and counters unchanged, pcsrc=0; the first clk after release -> pcsrc=1, flush_cnt increments once.
- Saturation: with CNT_W=4, force 20 load-use stalls -> stall_cnt stops at 15.
